// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus bundle between the core's MAXI master port and axi4_mem_slave.
// Carries all five AXI4 channels; the memory-side port stays on the slave module.
interface axi4_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 burst slave driving a single-port 64-bit synchronous memory, one beat at a time.
// Optional window check on each beat: define AXI4_MEM_SLAVE_RANGE_CHECK_EN.
module axi4_mem_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_AW     = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    axi4_mem_slave_if.slave         saxi,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    rr_ptr_reg, rr_ptr_next;   // 1: write wins the next tie
    logic [ID_WIDTH-1:0]     id_reg, id_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [7:0]              len_reg, len_next;
    logic [2:0]              size_reg, size_next;
    logic [1:0]              burst_reg, burst_next;
    logic [7:0]              beat_reg, beat_next;
    logic                    werr_reg, werr_next;
    logic                    oob_reg, oob_next;

    logic [ADDR_WIDTH-1:0]   addr_off;
    logic [ADDR_WIDTH-1:0]   addr_adv;
    logic                    in_range;
    logic                    last_beat;
    logic                    grant_rd, grant_wr;
    logic                    unused_off;

    logic                    arready, awready, wready, bvalid, rvalid, rlast;
    logic [1:0]              rresp;
    logic [DATA_WIDTH-1:0]   rdata;

    function automatic logic [ADDR_WIDTH-1:0] advance(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            sz,
        input logic [7:0]            ln,
        input logic [1:0]            bt
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << sz;
        mask = ((ADDR_WIDTH'(ln) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
        case (bt)
            2'b00:   advance = a;
            2'b10:   advance = (a & ~mask) | ((a + step) & mask);
            default: advance = a + step;
        endcase
    endfunction

    assign addr_off  = addr_reg - BASE_ADDR;
    assign addr_adv  = advance(addr_reg, size_reg, len_reg, burst_reg);
    assign last_beat = (beat_reg == len_reg);
    assign mem_addr  = addr_off[MEM_AW+2:3];

`ifdef AXI4_MEM_SLAVE_RANGE_CHECK_EN
    assign in_range   = (addr_off[ADDR_WIDTH-1:MEM_AW+3] == '0);
    assign unused_off = ^addr_off[2:0];
`else
    assign in_range   = 1'b1;
    assign unused_off = ^{addr_off[ADDR_WIDTH-1:MEM_AW+3], addr_off[2:0]};
`endif

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        id_next     = id_reg;
        addr_next   = addr_reg;
        len_next    = len_reg;
        size_next   = size_reg;
        burst_next  = burst_reg;
        beat_next   = beat_reg;
        werr_next   = werr_reg;
        oob_next    = oob_reg;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        arready     = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        rvalid      = 1'b0;
        rlast       = 1'b0;
        rresp       = 2'b00;
        rdata       = '0;
        mem_en      = 1'b0;
        mem_we      = '0;
        mem_wdata   = '0;

        case (state_reg)
            IDLE: begin
                // Readies are held low while reset is asserted, even though state is IDLE.
                grant_rd = !reset && saxi.arvalid && (!saxi.awvalid || !rr_ptr_reg);
                grant_wr = !reset && saxi.awvalid && (!saxi.arvalid || rr_ptr_reg);
                arready  = grant_rd;
                awready  = grant_wr;
                if (grant_rd) begin
                    id_next     = saxi.arid;
                    addr_next   = saxi.araddr;
                    len_next    = saxi.arlen;
                    size_next   = saxi.arsize;
                    burst_next  = saxi.arburst;
                    beat_next   = 8'd0;
                    rr_ptr_next = 1'b1;
                    state_next  = RD_REQ;
                end else if (grant_wr) begin
                    id_next     = saxi.awid;
                    addr_next   = saxi.awaddr;
                    len_next    = saxi.awlen;
                    size_next   = saxi.awsize;
                    burst_next  = saxi.awburst;
                    beat_next   = 8'd0;
                    werr_next   = 1'b0;
                    oob_next    = 1'b0;
                    rr_ptr_next = 1'b0;
                    state_next  = WR_DATA;
                end
            end
            RD_REQ: begin
                mem_en     = in_range;
                state_next = RD_RESP;
            end
            RD_RESP: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                rdata  = in_range ? mem_rdata : '0;
                rresp  = in_range ? 2'b00 : 2'b11;
                if (saxi.rready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                    end else begin
                        addr_next  = addr_adv;
                        beat_next  = beat_reg + 8'd1;
                        state_next = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (saxi.wvalid) begin
                    mem_en    = in_range;
                    mem_we    = in_range ? saxi.wstrb : '0;
                    mem_wdata = saxi.wdata;
                    // The beat count ends the burst; wlast only feeds the error flag.
                    if (saxi.wlast != last_beat) werr_next = 1'b1;
                    if (!in_range)               oob_next  = 1'b1;
                    if (last_beat) begin
                        state_next = WR_RESP;
                    end else begin
                        addr_next = addr_adv;
                        beat_next = beat_reg + 8'd1;
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (saxi.bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            id_reg     <= '0;
            addr_reg   <= '0;
            len_reg    <= '0;
            size_reg   <= '0;
            burst_reg  <= '0;
            beat_reg   <= '0;
            werr_reg   <= 1'b0;
            oob_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            id_reg     <= id_next;
            addr_reg   <= addr_next;
            len_reg    <= len_next;
            size_reg   <= size_next;
            burst_reg  <= burst_next;
            beat_reg   <= beat_next;
            werr_reg   <= werr_next;
            oob_reg    <= oob_next;
        end
    end

    assign saxi.arready = arready;
    assign saxi.awready = awready;
    assign saxi.wready  = wready;
    assign saxi.bvalid  = bvalid;
    assign saxi.bid     = id_reg;
    assign saxi.bresp   = oob_reg ? 2'b11 : (werr_reg ? 2'b10 : 2'b00);
    assign saxi.rvalid  = rvalid;
    assign saxi.rid     = id_reg;
    assign saxi.rdata   = rdata;
    assign saxi.rresp   = rresp;
    assign saxi.rlast   = rlast;

endmodule
